// File: rtl/rotary_encoder_capture_if.sv
// Memory-mapped slave bus and level interrupt of the rotary encoder front-end.
interface rotary_encoder_capture_if;
  logic [1:0]  avs_address;
  logic        avs_read;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic [31:0] avs_readdata;
  logic        ins_irq;

  modport master (
    output avs_address, avs_read, avs_write, avs_writedata,
    input  avs_readdata, ins_irq
  );

  modport slave (
    input  avs_address, avs_read, avs_write, avs_writedata,
    output avs_readdata, ins_irq
  );
endinterface

// File: rtl/rotary_encoder_capture.sv
// Rotary encoder front-end: synchronize, glitch-filter and 4x-decode the quadrature pins,
// debounce the push contact, and expose position/status/control as a bus slave with IRQ.
module rotary_encoder_capture #(
  parameter int POS_WIDTH     = 32,
  parameter int FILTER_CYCLES = 16
) (
  input  logic                     csi_MCLK_clk,
  input  logic                     rsi_MCLK_reset_n,
  input  logic                     coe_enc_a,
  input  logic                     coe_enc_b,
  input  logic                     coe_enc_k,
  rotary_encoder_capture_if.slave  bus
);
  localparam logic [7:0]                  FILT_LAST = 8'(FILTER_CYCLES - 1);
  localparam logic signed [POS_WIDTH-1:0] POS_ONE   = POS_WIDTH'(1);

  // Pin vectors are ordered {A, B, K} throughout.
  logic [2:0]      sync_p0;
  logic [2:0]      sync_p1;
  logic [2:0]      filt_p2;
  logic [2:0]      prev_p3;
  logic [2:0][7:0] filt_cnt;
  logic [1:0]      prime_cnt;
  logic            primed;

  logic signed [POS_WIDTH-1:0] position;
  logic [7:0]                  err_cnt;
  logic                        step_evt;
  logic                        btn_evt;
  logic [1:0]                  control;

  logic [1:0]  phase_delta;
  logic        step_fwd, step_rev, step_err, step_up, step_dn, press;
  logic        wr_pos, wr_stat, wr_ctrl;
  logic [31:0] rd_mux;

  function automatic logic [1:0] quad_phase(input logic [1:0] ab);
    case (ab)
      2'b00:   return 2'd0;
      2'b10:   return 2'd1;
      2'b11:   return 2'd2;
      default: return 2'd3;
    endcase
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Stage p0/p1: two-flop synchronizer; p2: per-pin stability filter; p3: previous filtered state
  always_ff @(posedge csi_MCLK_clk or negedge rsi_MCLK_reset_n) begin
    if (!rsi_MCLK_reset_n) begin
      sync_p0   <= '0;
      sync_p1   <= '0;
      filt_p2   <= '0;
      prev_p3   <= '0;
      filt_cnt  <= '0;
      prime_cnt <= '0;
      primed    <= 1'b0;
    end else begin
      sync_p0 <= {coe_enc_a, coe_enc_b, coe_enc_k};
      sync_p1 <= sync_p0;
      if (!primed) begin
        // First valid synchronized sample seeds the filters without producing events.
        if (prime_cnt == 2'd2) begin
          filt_p2 <= sync_p1;
          prev_p3 <= sync_p1;
          primed  <= 1'b1;
        end else begin
          prime_cnt <= prime_cnt + 2'd1;
        end
      end else begin
        prev_p3 <= filt_p2;
        for (int i = 0; i < 3; i++) begin
          if (sync_p1[i] == filt_p2[i]) begin
            filt_cnt[i] <= '0;
          end else if (filt_cnt[i] == FILT_LAST) begin
            filt_p2[i]  <= sync_p1[i];
            filt_cnt[i] <= '0;
          end else begin
            filt_cnt[i] <= filt_cnt[i] + 8'd1;
          end
        end
      end
    end
  end

  // Phase distance around the 00-10-11-01 cycle: 1 forward, 3 reverse, 2 means a skipped state.
  always_comb begin
    phase_delta = quad_phase(filt_p2[2:1]) - quad_phase(prev_p3[2:1]);
    step_fwd    = primed && (phase_delta == 2'd1);
    step_rev    = primed && (phase_delta == 2'd3);
    step_err    = primed && (phase_delta == 2'd2);
    step_up     = control[1] ? step_rev : step_fwd;
    step_dn     = control[1] ? step_fwd : step_rev;
    press       = primed && prev_p3[0] && !filt_p2[0];
  end

  assign wr_pos  = bus.avs_write && (bus.avs_address == 2'd0);
  assign wr_stat = bus.avs_write && (bus.avs_address == 2'd1);
  assign wr_ctrl = bus.avs_write && (bus.avs_address == 2'd2);

  always_comb begin
    rd_mux = '0;
    case (bus.avs_address)
      2'd0:    rd_mux = 32'(position);
      2'd1:    rd_mux = {16'd0, err_cnt, 5'd0, ~filt_p2[0], btn_evt, step_evt};
      2'd2:    rd_mux = {30'd0, control};
      default: rd_mux = '0;
    endcase
  end

  // Stage p4: position, sticky status, control, read data and interrupt
  always_ff @(posedge csi_MCLK_clk or negedge rsi_MCLK_reset_n) begin
    if (!rsi_MCLK_reset_n) begin
      position         <= '0;
      err_cnt          <= '0;
      step_evt         <= 1'b0;
      btn_evt          <= 1'b0;
      control          <= '0;
      bus.avs_readdata <= '0;
      bus.ins_irq      <= 1'b0;
    end else begin
      if (wr_pos) begin
        position <= bus.avs_writedata[POS_WIDTH-1:0];
      end else if (step_up) begin
        position <= position + POS_ONE;
      end else if (step_dn) begin
        position <= position - POS_ONE;
      end
      // A fresh event outranks a write-1-clear landing in the same cycle.
      step_evt <= step_up | step_dn | (step_evt & ~(wr_stat & bus.avs_writedata[0]));
      btn_evt  <= press | (btn_evt & ~(wr_stat & bus.avs_writedata[1]));
      if (step_err) begin
        err_cnt <= (wr_stat && bus.avs_writedata[8]) ? 8'd1 : sat_inc8(err_cnt);
      end else if (wr_stat && bus.avs_writedata[8]) begin
        err_cnt <= '0;
      end
      if (wr_ctrl) begin
        control <= bus.avs_writedata[1:0];
      end
      if (bus.avs_read) begin
        bus.avs_readdata <= rd_mux;
      end
      bus.ins_irq <= control[0] & (step_evt | btn_evt);
    end
  end
endmodule

// File: tb/tb_rotary_encoder_capture.sv
// Self-checking bench for rotary_encoder_capture: directed tables, timing corners and
// randomized pin activity against a sliding-window behavioural model.
module tb_rotary_encoder_capture;
  localparam int FILT = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic enc_a, enc_b, enc_k;
  logic [31:0] rd;

  rotary_encoder_capture_if bus_if ();

  rotary_encoder_capture #(.POS_WIDTH(32), .FILTER_CYCLES(FILT)) dut (
    .csi_MCLK_clk     (clk),
    .rsi_MCLK_reset_n (rst_n),
    .coe_enc_a        (enc_a),
    .coe_enc_b        (enc_b),
    .coe_enc_k        (enc_k),
    .bus              (bus_if.slave)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct { logic a; logic b; logic inv; logic [31:0] exp_pos; } quad_vec_t;
  typedef struct { logic [1:0] addr; logic [31:0] wdata; logic [31:0] exp_rd; } reg_vec_t;
  quad_vec_t qv [22];
  reg_vec_t  rv [4];

  // Behavioural model: a pin's filtered level flips once its last FILT samples all disagree.
  bit         model_on = 1'b0;
  bit [2:0]   m_hist [$];
  bit [2:0]   m_filt;
  bit [31:0]  m_pos;
  int         m_err;
  bit         m_step, m_btn, m_inv;

  function automatic int cycle_pos(input bit [1:0] ab);
    bit [1:0] seq [4];
    seq = '{2'b00, 2'b10, 2'b11, 2'b01};
    for (int i = 0; i < 4; i++) if (seq[i] == ab) return i;
    return 0;
  endfunction

  task automatic model_step();
    bit [2:0] nf;
    bit       all_diff;
    int       d;
    m_hist.push_back({enc_a, enc_b, enc_k});
    if (m_hist.size() > FILT) void'(m_hist.pop_front());
    nf = m_filt;
    if (m_hist.size() == FILT) begin
      for (int p = 0; p < 3; p++) begin
        all_diff = 1'b1;
        foreach (m_hist[j]) if (m_hist[j][p] == m_filt[p]) all_diff = 1'b0;
        if (all_diff) nf[p] = ~m_filt[p];
      end
    end
    d = (cycle_pos(nf[2:1]) - cycle_pos(m_filt[2:1]) + 4) % 4;
    if (d == 1 || d == 3) begin
      m_step = 1'b1;
      if ((d == 1) != m_inv) m_pos = m_pos + 32'd1;
      else                   m_pos = m_pos - 32'd1;
    end else if (d == 2 && m_err < 255) begin
      m_err++;
    end
    if (m_filt[0] && !nf[0]) m_btn = 1'b1;
    m_filt = nf;
  endtask

  task automatic tick();
    @(posedge clk);
    if (model_on) model_step();
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    bus_if.avs_address   = a;
    bus_if.avs_writedata = d;
    bus_if.avs_write     = 1'b1;
    tick();
    bus_if.avs_write     = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    bus_if.avs_address = a;
    bus_if.avs_read    = 1'b1;
    tick();
    bus_if.avs_read    = 1'b0;
    d = bus_if.avs_readdata;
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    qv[0]  = '{1'b0, 1'b1, 1'b0, 32'd1};
    qv[1]  = '{1'b0, 1'b0, 1'b0, 32'd2};
    qv[2]  = '{1'b1, 1'b0, 1'b0, 32'd3};
    qv[3]  = '{1'b1, 1'b1, 1'b0, 32'd4};
    qv[4]  = '{1'b0, 1'b1, 1'b0, 32'd5};
    qv[5]  = '{1'b0, 1'b0, 1'b0, 32'd6};
    qv[6]  = '{1'b1, 1'b0, 1'b0, 32'd7};
    qv[7]  = '{1'b1, 1'b1, 1'b0, 32'd8};
    qv[8]  = '{1'b0, 1'b1, 1'b0, 32'd9};
    qv[9]  = '{1'b0, 1'b0, 1'b0, 32'd10};
    qv[10] = '{1'b1, 1'b0, 1'b0, 32'd11};
    qv[11] = '{1'b1, 1'b1, 1'b0, 32'd12};
    qv[12] = '{1'b0, 1'b1, 1'b0, 32'd13};
    qv[13] = '{1'b0, 1'b0, 1'b0, 32'd14};
    qv[14] = '{1'b1, 1'b0, 1'b0, 32'd15};
    qv[15] = '{1'b1, 1'b1, 1'b0, 32'd16};
    qv[16] = '{1'b1, 1'b0, 1'b0, 32'd15};
    qv[17] = '{1'b0, 1'b0, 1'b0, 32'd14};
    qv[18] = '{1'b0, 1'b1, 1'b0, 32'd13};
    qv[19] = '{1'b1, 1'b1, 1'b0, 32'd12};
    qv[20] = '{1'b1, 1'b0, 1'b0, 32'd11};
    qv[21] = '{1'b1, 1'b1, 1'b1, 32'd10};

    rv[0] = '{2'd2, 32'hFFFF_FFFF, 32'd3};
    rv[1] = '{2'd3, 32'hFFFF_FFFF, 32'd0};
    rv[2] = '{2'd2, 32'h0000_0002, 32'd2};
    rv[3] = '{2'd2, 32'h0000_0000, 32'd0};

    rst_n = 1'b0;
    enc_a = 1'b1; enc_b = 1'b1; enc_k = 1'b1;
    bus_if.avs_address = '0; bus_if.avs_read = 1'b0;
    bus_if.avs_write = 1'b0; bus_if.avs_writedata = '0;
    repeat (3) tick();
    check("reset_readdata", bus_if.avs_readdata, 32'd0);
    check("reset_irq", {31'd0, bus_if.ins_irq}, 32'd0);
    rst_n = 1'b1;
    repeat (5) tick();
    bus_read(2'd0, rd); check("primed_pos", rd, 32'd0);
    bus_read(2'd1, rd); check("primed_status", rd, 32'd0);
    check("primed_irq", {31'd0, bus_if.ins_irq}, 32'd0);

    // Quadrature edge table, each level held 10 clocks.
    for (int i = 0; i < 22; i++) begin
      if (i == 21) bus_write(2'd2, {30'd0, qv[i].inv, 1'b0});
      enc_a = qv[i].a; enc_b = qv[i].b;
      repeat (10) tick();
      bus_read(2'd0, rd);
      check($sformatf("quad_pos%0d", i), rd, qv[i].exp_pos);
      if (i == 0) begin
        bus_read(2'd1, rd); check("first_step_status", rd, 32'h1);
      end
    end
    bus_write(2'd2, 32'd0);

    // Short glitch on A is rejected.
    bus_write(2'd1, 32'h103);
    enc_a = 1'b0; repeat (3) tick(); enc_a = 1'b1;
    repeat (12) tick();
    bus_read(2'd0, rd); check("glitch_pos", rd, 32'd10);
    bus_read(2'd1, rd); check("glitch_status", rd, 32'd0);

    // A held low: count lands on the FILT+3-th edge after the change.
    enc_a = 1'b0;
    repeat (6) tick();
    bus_if.avs_address = 2'd0; bus_if.avs_read = 1'b1;
    tick(); check("latency_before", bus_if.avs_readdata, 32'd10);
    tick(); check("latency_after", bus_if.avs_readdata, 32'd11);
    bus_if.avs_read = 1'b0;

    // Simultaneous A/B swaps are errors, saturating at 255.
    bus_write(2'd1, 32'h3);
    enc_a = 1'b1; enc_b = 1'b0;
    repeat (12) tick();
    bus_read(2'd0, rd); check("swap_pos", rd, 32'd11);
    bus_read(2'd1, rd); check("swap_status", rd, 32'h100);
    for (int i = 0; i < 300; i++) begin
      enc_a = ~enc_a; enc_b = ~enc_b;
      repeat (8) tick();
    end
    bus_read(2'd1, rd); check("err_saturated", rd, 32'hFF00);
    bus_read(2'd0, rd); check("swap_pos_after", rd, 32'd11);
    bus_write(2'd1, 32'h100);
    bus_read(2'd1, rd); check("err_cleared", rd, 32'd0);

    // Wrap from max positive; then a write colliding with a step.
    bus_write(2'd0, 32'h7FFF_FFFF);
    enc_a = 1'b1; enc_b = 1'b1;
    repeat (12) tick();
    bus_read(2'd0, rd); check("wrap_pos", rd, 32'h8000_0000);
    bus_write(2'd1, 32'h3);
    enc_a = 1'b0;
    repeat (6) tick();
    bus_write(2'd0, 32'h1234_5678);
    repeat (10) tick();
    bus_read(2'd0, rd); check("write_wins_pos", rd, 32'h1234_5678);
    bus_read(2'd1, rd); check("write_wins_status", rd, 32'h1);

    // Bouncing press gives one event and an interrupt.
    bus_write(2'd1, 32'h3);
    bus_write(2'd2, 32'h1);
    for (int i = 0; i < 2; i++) begin
      enc_k = 1'b0; repeat (2) tick();
      enc_k = 1'b1; repeat (2) tick();
    end
    enc_k = 1'b0;
    repeat (12) tick();
    check("press_irq", {31'd0, bus_if.ins_irq}, 32'd1);
    bus_read(2'd1, rd); check("press_status", rd, 32'h6);
    bus_write(2'd1, 32'h3);
    check("w1c_irq_same", {31'd0, bus_if.ins_irq}, 32'd1);
    tick();
    check("w1c_irq_next", {31'd0, bus_if.ins_irq}, 32'd0);
    bus_read(2'd1, rd); check("held_status", rd, 32'h4);
    enc_k = 1'b1;
    repeat (12) tick();
    bus_read(2'd1, rd); check("release_status", rd, 32'd0);
    check("release_irq", {31'd0, bus_if.ins_irq}, 32'd0);

    // Register access table.
    for (int i = 0; i < 4; i++) begin
      bus_write(rv[i].addr, rv[i].wdata);
      bus_read(rv[i].addr, rd);
      check($sformatf("reg_vec%0d", i), rd, rv[i].exp_rd);
    end

    // Randomized pin activity against the model.
    m_filt = {enc_a, enc_b, enc_k};
    m_hist.delete();
    model_on = 1'b1;
    for (int r = 0; r < 8; r++) begin
      m_inv = 1'($urandom_range(0, 1));
      bus_write(2'd2, {30'd0, m_inv, 1'b0});
      bus_write(2'd0, 32'd0); m_pos = '0;
      bus_write(2'd1, 32'h103); m_err = 0; m_step = 1'b0; m_btn = 1'b0;
      for (int c = 0; c < 200; c++) begin
        if ($urandom_range(0, 3) == 0) begin
          enc_a = 1'($urandom_range(0, 1));
          enc_b = 1'($urandom_range(0, 1));
        end
        if ($urandom_range(0, 15) == 0) enc_k = ~enc_k;
        tick();
      end
      repeat (20) tick();
      bus_read(2'd0, rd); check($sformatf("rand%0d_pos", r), rd, m_pos);
      bus_read(2'd1, rd);
      check($sformatf("rand%0d_status", r), rd,
            {16'd0, 8'(m_err), 5'd0, ~m_filt[0], m_btn, m_step});
    end
    model_on = 1'b0;

    // Asynchronous reset in the middle of operation.
    enc_a = 1'b1; enc_b = 1'b1; enc_k = 1'b1;
    repeat (12) tick();
    bus_write(2'd2, 32'h1);
    bus_write(2'd1, 32'h103);
    enc_a = 1'b0;
    repeat (12) tick();
    check("pre_reset_irq", {31'd0, bus_if.ins_irq}, 32'd1);
    bus_read(2'd2, rd); check("pre_reset_ctrl", rd, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_irq", {31'd0, bus_if.ins_irq}, 32'd0);
    check("async_reset_readdata", bus_if.avs_readdata, 32'd0);
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (5) tick();
    bus_read(2'd0, rd); check("post_reset_pos", rd, 32'd0);
    bus_read(2'd2, rd); check("post_reset_ctrl", rd, 32'd0);
    bus_read(2'd1, rd); check("post_reset_status", rd, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/rotary_encoder_capture.md
Name: rotary_encoder_capture

Overview:
- Front-end for the panel rotary encoder pins (two quadrature lines plus push contact) that hangs off the serial-host bus as a memory-mapped slave.
- Synchronizes and glitch-filters the raw pins, decodes 4x quadrature into a signed position, and debounces the push contact into a sticky press event.
- Raises a level interrupt on steps or presses.
- Sits directly downstream of the board pins and upstream of the system bus, replacing raw PIO sampling of the encoder.

Parameters:
- POS_WIDTH, 32, position counter width (8..32); sign-extended to 32 bits on read.
- FILTER_CYCLES, 16, consecutive stable clocks required before a pin change is accepted (1..255).

Ports:
- csi_MCLK_clk  input  1  system clock; all logic rising-edge.
- rsi_MCLK_reset_n  input  1  asynchronous active-low reset.
- coe_enc_a  input  1  raw quadrature A, asynchronous.
- coe_enc_b  input  1  raw quadrature B, asynchronous.
- coe_enc_k  input  1  raw push contact, active low, asynchronous.
- avs_address  input  2  register select.
- avs_read  input  1  read strobe.
- avs_write  input  1  write strobe.
- avs_writedata  input  32  write data.
- avs_readdata  output  32  read data; fixed read latency 1.
- ins_irq  output  1  level interrupt.

Behaviour:
- Reset: all registers 0, including avs_readdata, ins_irq, position, err_cnt, sticky bits, CONTROL, filters and the primed flag.
- Synchronizer: 2-flop chain per pin; s2 is valid on the 2nd edge after the pin changes.
- Filter, per pin, separate FILTER_CYCLES counter cnt:
  - s2 == filt: cnt <= 0.
  - s2 != filt: cnt increments; when cnt == FILTER_CYCLES-1, filt <= s2 and cnt <= 0.
  - Result: filt changes on the FILTER_CYCLES-th consecutive disagreeing cycle. A bounce resets cnt.
- Priming: primed is cleared by reset. On the 3rd edge after reset release, filt for all pins is loaded directly from s2, prev <= {filtA,filtB}, primed <= 1. No step and no press event are generated.
- Decoder (primed only), state {A,B}, prev updated every cycle:
  - 00->10->11->01->00 is +1 each edge.
  - The reverse order is -1.
  - Both bits changing: no count; err_cnt increments, saturating at 255.
  - CONTROL[1]=1 inverts direction.
  - Position updates one cycle after filt changes. Pin-to-position latency = FILTER_CYCLES+3 edges.
- Arithmetic: position wraps two's complement at POS_WIDTH. Max positive +1 gives min negative.
- Step event: any counted step sets STATUS[0]. Error transitions do not set it.
- Press event: filtered K falling 1->0 (primed) sets STATUS[1]. STATUS[2] = ~filtK (1 = held).
- Registers:
  - addr0 POSITION: R returns sign-extended position. W loads position <= writedata[POS_WIDTH-1:0].
  - addr1 STATUS: R returns [0] step_evt, [1] btn_evt, [2] btn_level, [15:8] err_cnt, others 0. W: bit0/bit1 write-1-clear, bit8=1 clears err_cnt.
  - addr2 CONTROL: R/W [0] irq_en, [1] dir_invert; other bits read 0.
  - addr3: reads 0, writes ignored.
- Read timing: avs_read at edge N gives avs_readdata valid after edge N+1 and held until the next read. Reads have no side effects.
- Simultaneous events:
  - POSITION write and a decoded step in the same cycle: write wins, step discarded, STATUS[0] still set.
  - W1C and a new event on the same sticky bit in the same cycle: set wins.
  - err_cnt clear and an error in the same cycle: result 1.
- ins_irq: registered, = CONTROL[0] & (STATUS[0] | STATUS[1]); asserts one cycle after the sticky bit sets.
- Reset mid-operation clears everything asynchronously. Priming repeats after release.

Test Plan:
- FILTER_CYCLES=4: reset with pins A=1,B=1,K=1, release -> after priming position=0, STATUS=0, irq=0.
- Drive 4 clean forward cycles (16 edges, each held 10 clk) -> POSITION reads 16 and STATUS[0]=1. Then 5 reverse edges -> 11. Set CONTROL[1], 1 forward edge -> 10.
- Glitch: A toggles for 3 clk then returns -> position unchanged, err_cnt 0. A held 4 clk -> count changes exactly at FILTER_CYCLES+3 edges after the pin change.
- Swap A and B simultaneously -> err_cnt=1, position unchanged. Repeat 300 times -> err_cnt saturates at 255. Write STATUS bit8 -> 0.
- Write POSITION 0x7FFFFFFF, one forward step -> read 0x80000000. Write position in the same cycle as a step -> written value exactly.
- CONTROL=1, K pressed (bouncing 2 clk, then held low) -> one btn_evt and irq high; STATUS[2]=1. W1C 0x3 -> irq low next cycle. Release K -> no new event.
